cpu_mon_ctrl: RTL

Host-side monitor controller that drives the CPU core's external control and memory-access ports. It parses a binary command stream arriving byte-by-byte from a UART receiver and turns it into I-RAM/D-RAM word writes and reads, CPU start/quit pulses and PC readback. Responses go back to a UART transmitter over a valid/ready byte interface. It sits between the UART blocks and the CPU top, and is the initiator of the memory-load and run-control ports the CPU top exposes.

---
 rtl/cpu_mon_ctrl_if.sv | 18 +
 rtl/cpu_mon_ctrl.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_mon_ctrl_if.sv
// rtl/cpu_mon_ctrl_if.sv - UART-side byte stream bundle (rx strobe in, tx valid/ready out) for cpu_mon_ctrl
interface cpu_mon_ctrl_if;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;

  modport master (
    output rx_data, rx_valid, tx_ready,
    input  tx_data, tx_valid
  );

  modport slave (
    input  rx_data, rx_valid, tx_ready,
    output tx_data, tx_valid
  );
endinterface

// File: rtl/cpu_mon_ctrl.sv
// rtl/cpu_mon_ctrl.sv - host monitor: parses UART commands into RAM load/readback, CPU start/quit and PC readback
// Optional inter-byte timeout in the operand phase is enabled by defining CPU_MON_TIMEOUT_EN.
module cpu_mon_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic          clk,
  input  logic          rst_n,
  cpu_mon_ctrl_if.slave bus,
  output logic          cpu_start_o,
  output logic          quit_cmd_o,
  output logic [31:2]   start_adr_o,
  output logic [13:2]   i_ram_radr_o,
  output logic [13:2]   i_ram_wadr_o,
  output logic [31:0]   i_ram_wdata_o,
  output logic          i_ram_wen_o,
  output logic          i_read_sel_o,
  input  logic [31:0]   i_ram_rdata_i,
  output logic [13:2]   d_ram_radr_o,
  output logic [13:2]   d_ram_wadr_o,
  output logic [31:0]   d_ram_wdata_o,
  output logic          d_ram_wen_o,
  output logic          d_read_sel_o,
  input  logic [31:0]   d_ram_rdata_i,
  input  logic [31:0]   pc_data_i
);

  localparam logic [7:0] CMD_WI  = 8'h01;
  localparam logic [7:0] CMD_WD  = 8'h02;
  localparam logic [7:0] CMD_RI  = 8'h03;
  localparam logic [7:0] CMD_RD  = 8'h04;
  localparam logic [7:0] CMD_GO  = 8'h05;
  localparam logic [7:0] CMD_QT  = 8'h06;
  localparam logic [7:0] CMD_PC  = 8'h07;
  localparam logic [7:0] RSP_OK  = 8'hAA;
  localparam logic [7:0] RSP_ERR = 8'hEE;

  typedef enum logic [2:0] {
    S_IDLE, S_ARG, S_EXEC, S_RD_WAIT, S_RD_CAP, S_TX
  } state_t;

  state_t        state_q;
  logic [7:0]    cmd_q;
  logic [2:0]    cnt_q;
  logic [47:0]   opnd_q;
  logic [47:0]   opnd_d;
  logic [7:0]    tx_data_q;
  logic          tx_valid_q;
  logic [23:0]   tx_shift_q;
  logic [1:0]    tx_left_q;
  logic [31:2]   start_adr_q;
  logic          cpu_start_q;
  logic          quit_q;
  logic [13:2]   i_radr_q, i_wadr_q, d_radr_q, d_wadr_q;
  logic [31:0]   i_wdata_q, d_wdata_q;
  logic          i_wen_q, d_wen_q, i_sel_q, d_sel_q;
  logic [31:0]   rd_word;
  logic          tx_accept;
  logic          to_expire;
  logic          unused_opnd;

  assign opnd_d      = {opnd_q[39:0], bus.rx_data};
  assign rd_word     = (cmd_q == CMD_RD) ? d_ram_rdata_i : i_ram_rdata_i;
  assign tx_accept   = tx_valid_q && bus.tx_ready;
  // The top operand byte is shifted out unused: the last operand arrives straight from rx_data.
  assign unused_opnd = &opnd_q[47:40];

`ifdef CPU_MON_TIMEOUT_EN
  localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TO_W-1:0] to_cnt_q;

  assign to_expire = (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      to_cnt_q <= '0;
    end else if (state_q != S_ARG || bus.rx_valid) begin
      to_cnt_q <= '0;
    end else if (!to_expire) begin
      to_cnt_q <= to_cnt_q + 1'b1;
    end
  end
`else
  logic unused_timeout;
  assign to_expire      = 1'b0;
  assign unused_timeout = (TIMEOUT_CYCLES != 0);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cmd_q       <= '0;
      cnt_q       <= '0;
      opnd_q      <= '0;
      tx_data_q   <= '0;
      tx_valid_q  <= 1'b0;
      tx_shift_q  <= '0;
      tx_left_q   <= '0;
      start_adr_q <= '0;
      cpu_start_q <= 1'b0;
      quit_q      <= 1'b0;
      i_radr_q    <= '0;
      i_wadr_q    <= '0;
      i_wdata_q   <= '0;
      i_wen_q     <= 1'b0;
      i_sel_q     <= 1'b0;
      d_radr_q    <= '0;
      d_wadr_q    <= '0;
      d_wdata_q   <= '0;
      d_wen_q     <= 1'b0;
      d_sel_q     <= 1'b0;
    end else begin
      // Strobes are armed on the transition into EXEC, so they are high for exactly that cycle.
      i_wen_q     <= 1'b0;
      d_wen_q     <= 1'b0;
      cpu_start_q <= 1'b0;
      quit_q      <= 1'b0;

      if (tx_accept) begin
        if (tx_left_q == 2'd0) begin
          tx_valid_q <= 1'b0;
        end else begin
          tx_data_q  <= tx_shift_q[23:16];
          tx_shift_q <= {tx_shift_q[15:0], 8'h00};
          tx_left_q  <= tx_left_q - 2'd1;
        end
      end

      case (state_q)
        S_IDLE: begin
          if (bus.rx_valid) begin
            cmd_q <= bus.rx_data;
            case (bus.rx_data)
              CMD_WI, CMD_WD: begin cnt_q <= 3'd5; state_q <= S_ARG; end
              CMD_RI, CMD_RD: begin cnt_q <= 3'd1; state_q <= S_ARG; end
              CMD_GO:         begin cnt_q <= 3'd3; state_q <= S_ARG; end
              CMD_QT:         begin quit_q <= 1'b1; state_q <= S_EXEC; end
              CMD_PC:         state_q <= S_EXEC;
              default: begin
                tx_data_q  <= RSP_ERR;
                tx_valid_q <= 1'b1;
                tx_left_q  <= 2'd0;
                state_q    <= S_TX;
              end
            endcase
          end
        end

        S_ARG: begin
          if (bus.rx_valid) begin
            opnd_q <= opnd_d;
            if (cnt_q == 3'd0) begin
              state_q <= S_EXEC;
              case (cmd_q)
                CMD_WI: begin i_wadr_q <= opnd_d[43:32]; i_wdata_q <= opnd_d[31:0]; i_wen_q <= 1'b1; end
                CMD_WD: begin d_wadr_q <= opnd_d[43:32]; d_wdata_q <= opnd_d[31:0]; d_wen_q <= 1'b1; end
                CMD_RI: begin i_radr_q <= opnd_d[11:0]; i_sel_q <= 1'b1; end
                CMD_RD: begin d_radr_q <= opnd_d[11:0]; d_sel_q <= 1'b1; end
                CMD_GO: begin start_adr_q <= opnd_d[31:2]; cpu_start_q <= 1'b1; end
                default: ;
              endcase
            end else begin
              cnt_q <= cnt_q - 3'd1;
            end
          end else if (to_expire) begin
            tx_data_q  <= RSP_ERR;
            tx_valid_q <= 1'b1;
            tx_left_q  <= 2'd0;
            state_q    <= S_TX;
          end
        end

        S_EXEC: begin
          if (cmd_q == CMD_RI || cmd_q == CMD_RD) begin
            state_q <= S_RD_WAIT;
          end else begin
            state_q    <= S_TX;
            tx_valid_q <= 1'b1;
            if (cmd_q == CMD_PC) begin
              tx_data_q  <= pc_data_i[31:24];
              tx_shift_q <= pc_data_i[23:0];
              tx_left_q  <= 2'd3;
            end else begin
              tx_data_q <= RSP_OK;
              tx_left_q <= 2'd0;
            end
          end
        end

        // RAM data is valid one cycle after the address; capture it on the way into RD_CAP.
        S_RD_WAIT: begin
          i_sel_q    <= 1'b0;
          d_sel_q    <= 1'b0;
          tx_data_q  <= rd_word[31:24];
          tx_shift_q <= rd_word[23:0];
          tx_left_q  <= 2'd3;
          tx_valid_q <= 1'b1;
          state_q    <= S_RD_CAP;
        end

        S_RD_CAP: state_q <= S_TX;

        S_TX: begin
          if (tx_accept && tx_left_q == 2'd0) begin
            state_q <= S_IDLE;
          end
        end

        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.tx_data   = tx_data_q;
  assign bus.tx_valid  = tx_valid_q;
  assign cpu_start_o   = cpu_start_q;
  assign quit_cmd_o    = quit_q;
  assign start_adr_o   = start_adr_q;
  assign i_ram_radr_o  = i_radr_q;
  assign i_ram_wadr_o  = i_wadr_q;
  assign i_ram_wdata_o = i_wdata_q;
  assign i_ram_wen_o   = i_wen_q;
  assign i_read_sel_o  = i_sel_q;
  assign d_ram_radr_o  = d_radr_q;
  assign d_ram_wadr_o  = d_wadr_q;
  assign d_ram_wdata_o = d_wdata_q;
  assign d_ram_wen_o   = d_wen_q;
  assign d_read_sel_o  = d_sel_q;

endmodule
